// File: rtl/br_scn_injector.sv
// Scenario-table traffic injector: replays timestamped BrLite requests for one
// source ID onto the local port, firing strictly in table order.

package br_scn_pkg;
    typedef enum logic [1:0] {
        BR_SVC_UNI   = 2'd0,
        BR_SVC_MCAST = 2'd1,
        BR_SVC_ALL   = 2'd2,
        BR_SVC_RSVD  = 2'd3
    } br_svc_t;
endpackage

// state   | meaning
// IDLE    | table writable, waiting for start_i
// SCAN    | inspect table[idx]: skip foreign entry, stop/loop at end
// WAIT_TS | own entry found, wait for now >= ts
// SEND    | br_req_o high until br_ack_i
// DONE    | scenario finished or aborted, table writable
module br_scn_injector
    import br_scn_pkg::*;
#(
    parameter int unsigned PE_ID     = 0,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned TS_W      = 32,
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned LOOP_EN   = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cfg_we_i,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr_i,
    input  logic [TS_W-1:0]            cfg_ts_i,
    input  logic [ID_W-1:0]            cfg_src_i,
    input  logic [ID_W-1:0]            cfg_tgt_i,
    input  logic [PAYLOAD_W-1:0]       cfg_payload_i,
    input  br_svc_t                    cfg_svc_i,
    input  logic [$clog2(DEPTH):0]     n_entries_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic                       br_req_o,
    input  logic                       br_ack_i,
    output logic [ID_W-1:0]            br_tgt_o,
    output logic [PAYLOAD_W-1:0]       br_payload_o,
    output br_svc_t                    br_svc_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [15:0]                sent_cnt_o,
    output logic [15:0]                late_cnt_o,
    output logic [TS_W-1:0]            now_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        WAIT_TS = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [TS_W-1:0]      tab_ts  [DEPTH];
    logic [ID_W-1:0]      tab_src [DEPTH];
    logic [ID_W-1:0]      tab_tgt [DEPTH];
    logic [PAYLOAD_W-1:0] tab_pl  [DEPTH];
    br_svc_t              tab_svc [DEPTH];

    logic [CW-1:0]   idx, idx_nxt;
    logic [TS_W-1:0] now, now_nxt, now_adv;
    logic [PW-1:0]   presc, presc_nxt;
    logic [15:0]     sent_cnt, late_cnt;

    logic            active;
    logic            cfg_open;
    logic            at_end;
    logic            own;
    logic            cnt_clr;
    logic            sent_inc;
    logic            late_inc;
    logic            out_load;

    logic [AW-1:0]        rd_idx;
    logic [TS_W-1:0]      cur_ts;
    logic [ID_W-1:0]      cur_src;
    logic [ID_W-1:0]      cur_tgt;
    logic [PAYLOAD_W-1:0] cur_pl;
    br_svc_t              cur_svc;

    assign active   = (state == SCAN) || (state == WAIT_TS) || (state == SEND);
    assign cfg_open = (state == IDLE) || (state == DONE);

    assign rd_idx  = idx[AW-1:0];
    assign cur_ts  = tab_ts[rd_idx];
    assign cur_src = tab_src[rd_idx];
    assign cur_tgt = tab_tgt[rd_idx];
    assign cur_pl  = tab_pl[rd_idx];
    assign cur_svc = tab_svc[rd_idx];

    assign at_end = (idx >= n_entries_i) || (idx >= CW'(DEPTH));
    assign own    = (cur_src == ID_W'(PE_ID));

    // Value now will hold next cycle; WAIT_TS compares against it so that an
    // on-time entry is presented in SEND with now_o equal to its timestamp.
    assign now_adv = ((presc == '0) && (now != '1)) ? now + 1'b1 : now;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tab_ts[i]  <= '0;
                tab_src[i] <= '0;
                tab_tgt[i] <= '0;
                tab_pl[i]  <= '0;
                tab_svc[i] <= BR_SVC_UNI;
            end
        end else if (cfg_we_i && cfg_open) begin
            tab_ts[cfg_addr_i]  <= cfg_ts_i;
            tab_src[cfg_addr_i] <= cfg_src_i;
            tab_tgt[cfg_addr_i] <= cfg_tgt_i;
            tab_pl[cfg_addr_i]  <= cfg_payload_i;
            tab_svc[cfg_addr_i] <= cfg_svc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            idx   <= '0;
            now   <= '0;
            presc <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            now   <= now_nxt;
            presc <= presc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        now_nxt   = now;
        presc_nxt = presc;
        cnt_clr   = 1'b0;
        sent_inc  = 1'b0;
        late_inc  = 1'b0;
        out_load  = 1'b0;

        if (active) begin
            now_nxt   = now_adv;
            presc_nxt = (presc == '0) ? PRESC_LOAD : presc - 1'b1;
        end

        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                    now_nxt   = '0;
                    presc_nxt = PRESC_LOAD;
                    cnt_clr   = 1'b1;
                end
            end
            SCAN: begin
                if (at_end) begin
                    if (LOOP_EN != 0) begin
                        idx_nxt   = '0;
                        now_nxt   = '0;
                        presc_nxt = PRESC_LOAD;
                    end else begin
                        state_nxt = DONE;
                    end
                end else if (own) begin
                    state_nxt = WAIT_TS;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            WAIT_TS: begin
                if (now_adv >= cur_ts) begin
                    state_nxt = SEND;
                    out_load  = 1'b1;
                    late_inc  = (now_adv > cur_ts);
                end
            end
            SEND: begin
                if (br_ack_i) begin
                    sent_inc  = 1'b1;
                    idx_nxt   = idx + 1'b1;
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides everything except a transfer completing this cycle.
        if (abort_i) begin
            state_nxt = DONE;
            cnt_clr   = 1'b0;
            out_load  = 1'b0;
            late_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sent_cnt <= '0;
            late_cnt <= '0;
        end else if (cnt_clr) begin
            sent_cnt <= '0;
            late_cnt <= '0;
        end else begin
            if (sent_inc && (sent_cnt != 16'hFFFF)) begin
                sent_cnt <= sent_cnt + 16'd1;
            end
            if (late_inc && (late_cnt != 16'hFFFF)) begin
                late_cnt <= late_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_tgt_o     <= '0;
            br_payload_o <= '0;
            br_svc_o     <= BR_SVC_UNI;
        end else if (out_load) begin
            br_tgt_o     <= cur_tgt;
            br_payload_o <= cur_pl;
            br_svc_o     <= cur_svc;
        end
    end

    assign br_req_o   = (state == SEND);
    assign busy_o     = active;
    assign done_o     = (state == DONE);
    assign sent_cnt_o = sent_cnt;
    assign late_cnt_o = late_cnt;
    assign now_o      = now;

endmodule

// File: tb/tb_br_scn_injector.sv
// Directed + randomized bench for br_scn_injector; expectations come from a
// cycle-arithmetic model of scan/wait/send timing kept in the bench.
module tb_br_scn_injector;
    import br_scn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance a: PE_ID 4, TICK_DIV 1, single pass
    logic        a_we, a_start, a_abort, a_ack;
    logic [2:0]  a_addr;
    logic [15:0] a_ts;
    logic [7:0]  a_src, a_tgt;
    logic [31:0] a_pl;
    br_svc_t     a_svc;
    logic [3:0]  a_n;
    logic        a_req, a_busy, a_done;
    logic [7:0]  a_tgt_o;
    logic [31:0] a_pl_o;
    br_svc_t     a_svc_o;
    logic [15:0] a_sent, a_late, a_now;

    // instance b: PE_ID 4, TICK_DIV 4, looping
    logic        b_we, b_start, b_abort, b_ack;
    logic [1:0]  b_addr;
    logic [15:0] b_ts;
    logic [7:0]  b_src, b_tgt;
    logic [31:0] b_pl;
    br_svc_t     b_svc;
    logic [2:0]  b_n;
    logic        b_req, b_busy, b_done;
    logic [7:0]  b_tgt_o;
    logic [31:0] b_pl_o;
    br_svc_t     b_svc_o;
    logic [15:0] b_sent, b_late, b_now;

    br_scn_injector #(.PE_ID(4), .DEPTH(8), .ID_W(8), .TS_W(16), .PAYLOAD_W(32),
                      .TICK_DIV(1), .LOOP_EN(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_we_i(a_we), .cfg_addr_i(a_addr), .cfg_ts_i(a_ts), .cfg_src_i(a_src),
        .cfg_tgt_i(a_tgt), .cfg_payload_i(a_pl), .cfg_svc_i(a_svc),
        .n_entries_i(a_n), .start_i(a_start), .abort_i(a_abort),
        .br_req_o(a_req), .br_ack_i(a_ack), .br_tgt_o(a_tgt_o), .br_payload_o(a_pl_o),
        .br_svc_o(a_svc_o), .busy_o(a_busy), .done_o(a_done),
        .sent_cnt_o(a_sent), .late_cnt_o(a_late), .now_o(a_now)
    );

    br_scn_injector #(.PE_ID(4), .DEPTH(4), .ID_W(8), .TS_W(16), .PAYLOAD_W(32),
                      .TICK_DIV(4), .LOOP_EN(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_we_i(b_we), .cfg_addr_i(b_addr), .cfg_ts_i(b_ts), .cfg_src_i(b_src),
        .cfg_tgt_i(b_tgt), .cfg_payload_i(b_pl), .cfg_svc_i(b_svc),
        .n_entries_i(b_n), .start_i(b_start), .abort_i(b_abort),
        .br_req_o(b_req), .br_ack_i(b_ack), .br_tgt_o(b_tgt_o), .br_payload_o(b_pl_o),
        .br_svc_o(b_svc_o), .busy_o(b_busy), .done_o(b_done),
        .sent_cnt_o(b_sent), .late_cnt_o(b_late), .now_o(b_now)
    );

    int n_chk = 0;
    int n_fail = 0;

    int          m_ts  [8];
    int          m_src [8];
    int          m_tgt [8];
    logic [31:0] m_pl  [8];
    int          m_svc [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input int a, input int ts, input int src, input int tgt,
                        input logic [31:0] pl, input int svc);
        a_we = 1'b1; a_addr = 3'(a); a_ts = 16'(ts); a_src = 8'(src);
        a_tgt = 8'(tgt); a_pl = pl; a_svc = br_svc_t'(2'(svc));
        m_ts[a] = ts; m_src[a] = src; m_tgt[a] = tgt; m_pl[a] = pl; m_svc[a] = svc;
        @(negedge clk);
        a_we = 1'b0;
    endtask

    task automatic wr_b(input int a, input int ts, input int tgt, input logic [31:0] pl);
        b_we = 1'b1; b_addr = 2'(a); b_ts = 16'(ts); b_src = 8'd4;
        b_tgt = 8'(tgt); b_pl = pl; b_svc = BR_SVC_ALL;
        @(negedge clk);
        b_we = 1'b0;
    endtask

    // Start instance a and follow the scenario: skip costs one cycle, an own
    // entry fires at cycle max(scan+2, ts) with now_o == that cycle.
    task automatic run_a(input int n, input int dmin, input int dmax);
        int k, cursor, exp_c, exp_sent, exp_late, g, d;
        a_n = 4'(n);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        k = 0;
        chk("busy_after_start", a_busy, 1);
        chk("now_after_start", a_now, 0);
        cursor = 0; exp_sent = 0; exp_late = 0;
        for (int i = 0; i < n; i++) begin
            if (m_src[i] != 4) begin
                cursor++;
                continue;
            end
            exp_c = (cursor + 2 > m_ts[i]) ? cursor + 2 : m_ts[i];
            if (exp_c > m_ts[i]) exp_late++;
            g = 0;
            while (!a_req && g < 2000) begin
                @(negedge clk); k++; g++;
            end
            chk("req_cycle", k, exp_c);
            chk("req_now", a_now, exp_c);
            chk("req_tgt", a_tgt_o, m_tgt[i]);
            chk("req_payload", a_pl_o, m_pl[i]);
            chk("req_svc", a_svc_o, m_svc[i]);
            d = $urandom_range(dmax, dmin);
            for (int j = 0; j < d; j++) begin
                @(negedge clk); k++;
                chk("req_hold", a_req, 1);
                chk("tgt_hold", a_tgt_o, m_tgt[i]);
                chk("payload_hold", a_pl_o, m_pl[i]);
                chk("svc_hold", a_svc_o, m_svc[i]);
            end
            a_ack = 1'b1;
            @(negedge clk); k++;
            a_ack = 1'b0;
            exp_sent++;
            chk("req_drop", a_req, 0);
            cursor = k;
        end
        g = 0;
        while (!a_done && g < 2000) begin
            @(negedge clk); k++; g++;
        end
        chk("done_seen", a_done, 1);
        chk("done_cycle", k, cursor + 1);
        chk("done_now", a_now, cursor + 1);
        chk("done_busy", a_busy, 0);
        chk("sent_cnt", a_sent, exp_sent);
        chk("late_cnt", a_late, exp_late);
    endtask

    initial begin
        int k, g, xfers, r;
        logic seen;
        rst_n = 1'b1;
        a_we = 0; a_start = 0; a_abort = 0; a_ack = 0; a_addr = 0; a_ts = 0;
        a_src = 0; a_tgt = 0; a_pl = 0; a_svc = BR_SVC_UNI; a_n = 0;
        b_we = 0; b_start = 0; b_abort = 0; b_ack = 0; b_addr = 0; b_ts = 0;
        b_src = 0; b_tgt = 0; b_pl = 0; b_svc = BR_SVC_UNI; b_n = 0;
        for (int i = 0; i < 8; i++) begin
            m_ts[i] = 0; m_src[i] = 0; m_tgt[i] = 0; m_pl[i] = 0; m_svc[i] = 0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a_req", a_req, 0);      chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);    chk("rst_a_now", a_now, 0);
        chk("rst_a_sent", a_sent, 0);    chk("rst_a_late", a_late, 0);
        chk("rst_a_tgt", a_tgt_o, 0);    chk("rst_a_pl", a_pl_o, 0);
        chk("rst_a_svc", a_svc_o, 0);
        chk("rst_b_req", b_req, 0);      chk("rst_b_busy", b_busy, 0);
        chk("rst_b_done", b_done, 0);    chk("rst_b_now", b_now, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single own entry, ack always ready: req when now_o == 4
        wr_a(0, 4, 4, 0, 32'h01, 2);
        run_a(1, 0, 0);

        // two foreign entries skipped before the own one
        wr_a(0, 10, 8, 1, 32'hAA, 0);
        wr_a(1, 10, 0, 2, 32'hBB, 1);
        wr_a(2, 10, 4, 3, 32'h03, 2);
        run_a(3, 0, 2);

        // out-of-order timestamps: second one fires late, right after the first
        wr_a(0, 420, 4, 5, 32'h420, 1);
        wr_a(1, 410, 4, 6, 32'h410, 2);
        run_a(2, 0, 0);

        // ack withheld for 20 cycles
        wr_a(0, 5, 4, 7, 32'hDEADBEEF, 3);
        run_a(1, 20, 20);

        // empty scenario finishes one cycle after start
        run_a(0, 0, 0);

        // randomized tables
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 8; i++) begin
                r = $urandom_range(2, 0);
                wr_a(i, $urandom_range(60, 0), (r < 2) ? 4 : $urandom_range(255, 0),
                     $urandom_range(255, 0), $urandom, $urandom_range(3, 0));
            end
            run_a($urandom_range(8, 1), 0, 3);
        end

        // write and start while busy are both ignored
        wr_a(0, 30, 4, 9, 32'h55, 1);
        a_n = 4'd1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        k = 0;
        repeat (10) begin @(negedge clk); k++; end
        a_we = 1'b1; a_addr = 3'd0; a_pl = 32'h66; a_start = 1'b1;
        @(negedge clk); k++;
        a_we = 1'b0; a_start = 1'b0;
        chk("busy_start_ignored_now", a_now, 11);
        g = 0;
        while (!a_req && g < 200) begin @(negedge clk); k++; g++; end
        chk("busy_write_req_cycle", k, 30);
        chk("busy_write_payload", a_pl_o, 32'h55);
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
        g = 0;
        while (!a_done && g < 50) begin @(negedge clk); g++; end
        chk("busy_write_sent", a_sent, 1);

        // abort while waiting for the timestamp
        wr_a(0, 40, 4, 1, 32'h77, 0);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (5) @(negedge clk);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chk("abort_wait_done", a_done, 1);
        chk("abort_wait_busy", a_busy, 0);
        chk("abort_wait_req", a_req, 0);
        seen = 1'b0;
        repeat (50) begin @(negedge clk); seen = seen | a_req; end
        chk("abort_wait_no_req", seen, 0);
        chk("abort_wait_sent", a_sent, 0);

        // abort coinciding with ack: transfer counts
        wr_a(0, 3, 4, 2, 32'h88, 1);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        g = 0;
        while (!a_req && g < 100) begin @(negedge clk); g++; end
        chk("abort_ack_req_seen", a_req, 1);
        a_abort = 1'b1; a_ack = 1'b1;
        @(negedge clk);
        a_abort = 1'b0; a_ack = 1'b0;
        chk("abort_ack_done", a_done, 1);
        chk("abort_ack_sent", a_sent, 1);
        chk("abort_ack_req", a_req, 0);

        // abort beats start in DONE: nothing restarts, counters kept
        a_start = 1'b1; a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_abort = 1'b0;
        chk("abort_start_done", a_done, 1);
        chk("abort_start_busy", a_busy, 0);
        chk("abort_start_sent", a_sent, 1);

        // reset in the middle of SEND
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        g = 0;
        while (!a_req && g < 100) begin @(negedge clk); g++; end
        chk("rst_send_req_seen", a_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_send_req", a_req, 0);    chk("rst_send_tgt", a_tgt_o, 0);
        chk("rst_send_pl", a_pl_o, 0);    chk("rst_send_svc", a_svc_o, 0);
        chk("rst_send_sent", a_sent, 0);  chk("rst_send_now", a_now, 0);
        chk("rst_send_busy", a_busy, 0);  chk("rst_send_done", a_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_ts[i] = 0; m_src[i] = 0; m_tgt[i] = 0; m_pl[i] = 0; m_svc[i] = 0;
        end
        @(negedge clk);
        run_a(1, 0, 0);

        // TICK_DIV 4: ts 10 fires about 40 cycles after start
        wr_b(0, 10, 3, 32'h77);
        b_n = 3'd1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        k = 0;
        while (!b_req && k < 500) begin @(negedge clk); k++; end
        chk("b_req_cycle_window", (k >= 39 && k <= 41), 1);
        chk("b_req_now", b_now, 10);
        chk("b_req_payload", b_pl_o, 32'h77);
        b_ack = 1'b1; b_abort = 1'b1;
        @(negedge clk);
        b_ack = 1'b0; b_abort = 1'b0;
        chk("b_abort_done", b_done, 1);
        chk("b_abort_sent", b_sent, 1);

        // looping scenario, two own entries, three passes then abort
        wr_b(0, 3, 1, 32'h31);
        wr_b(1, 6, 2, 32'h62);
        b_n = 3'd2;
        b_ack = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        xfers = 0;
        g = 0;
        while (xfers < 6 && g < 2000) begin
            if (b_req) begin
                xfers++;
                chk("b_loop_now", b_now, (xfers % 2 == 1) ? 3 : 6);
                if (xfers == 6) b_abort = 1'b1;
            end
            @(negedge clk); g++;
        end
        b_abort = 1'b0;
        b_ack = 1'b0;
        chk("b_loop_xfers", xfers, 6);
        chk("b_loop_done", b_done, 1);
        chk("b_loop_sent", b_sent, 6);
        chk("b_loop_late", b_late, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
